systolic_drain: RTL and testbench

//  Consumer end of the systolic array's accumulator (producer) interface. Takes
//  the array's flattened accumulator bus z_i with one valid bit per lane. Drains

---
 rtl/systolic_drain.sv | 85 ++++++++
 tb/tb_systolic_drain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// Drains systolic-array accumulator lanes in strict index order onto a single
// valid/ready stream, tagging each result with its lane index and end-of-tile.
module systolic_drain #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned count_width_p  = 16,
  localparam int unsigned n_lp          = array_width_p * array_height_p,
  localparam int unsigned ptr_width_lp  = (n_lp > 1) ? $clog2(n_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic [width_p*n_lp-1:0]   z_i,
  input  logic [n_lp-1:0]           z_valid_i,
  output logic [n_lp-1:0]           z_yumi_o,
  output logic [width_p-1:0]        data_o,
  output logic [ptr_width_lp-1:0]   idx_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      tile_done_o,
  output logic [count_width_p-1:0]  tile_count_o
);

  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(n_lp - 1);

  logic [ptr_width_lp-1:0] ptr;
  logic [width_p-1:0]      lane_data;
  logic                    lane_valid;
  logic                    at_last;
  logic                    open;
  logic                    capture;

  // Lane select by loop so no dynamic index can fall outside the bus for any N.
  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    for (int unsigned k = 0; k < n_lp; k++) begin
      if (ptr == ptr_width_lp'(k)) begin
        lane_data  = z_i[width_p*k +: width_p];
        lane_valid = z_valid_i[k];
      end
    end
  end

  always_comb begin
    at_last = (ptr == last_ptr_lp);
    open    = !valid_o || ready_i;
    // reset_n_i gates capture so yumi drops the instant reset asserts.
    capture = reset_n_i && en_i && open && lane_valid;
  end

  always_comb begin
    z_yumi_o = '0;
    for (int unsigned k = 0; k < n_lp; k++) begin
      if (capture && (ptr == ptr_width_lp'(k))) z_yumi_o[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr          <= '0;
      data_o       <= '0;
      idx_o        <= '0;
      last_o       <= 1'b0;
      valid_o      <= 1'b0;
      tile_done_o  <= 1'b0;
      tile_count_o <= '0;
    end else begin
      tile_done_o <= capture && at_last;
      if (capture) begin
        data_o  <= lane_data;
        idx_o   <= ptr;
        last_o  <= at_last;
        valid_o <= 1'b1;
        ptr     <= at_last ? '0 : ptr + 1'b1;
        if (at_last) tile_count_o <= tile_count_o + 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain on a 2x2 array with a 2-bit tile counter.
module tb_systolic_drain;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           ready = 1'b0;
  logic [W*N-1:0] z;
  logic [N-1:0]   zv = '0;
  logic [N-1:0]   yumi;
  logic [W-1:0]   data;
  logic [1:0]     idx;
  logic           last;
  logic           valid;
  logic           tile_done;
  logic [1:0]     tile_count;

  systolic_drain #(
    .width_p(W), .array_width_p(2), .array_height_p(2), .count_width_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .z_i(z), .z_valid_i(zv),
    .z_yumi_o(yumi), .data_o(data), .idx_o(idx), .last_o(last),
    .valid_o(valid), .ready_i(ready), .tile_done_o(tile_done),
    .tile_count_o(tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  i;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lane(input int unsigned k);
    exp_t e;
    e.d = 32'((k + 1) * 10);
    e.i = 2'(k);
    e.l = (k == N - 1);
    q.push_back(e);
  endtask

  task automatic push_tile();
    for (int unsigned k = 0; k < N; k++) push_lane(k);
  endtask

  task automatic drain(input int unsigned s, input int unsigned e);
    for (int unsigned k = s; k < e; k++) begin
      @(negedge clk);
      check("yumi_order", 64'(yumi), 64'(1) << k);
      tick();
    end
  endtask

  task automatic do_reset(input bit check_state);
    rst_n = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    zv    = '0;
    repeat (2) @(posedge clk);
    #1;
    if (check_state) begin
      check("rst_valid", 64'(valid), 0);
      check("rst_data", 64'(data), 0);
      check("rst_idx", 64'(idx), 0);
      check("rst_last", 64'(last), 0);
      check("rst_tile_done", 64'(tile_done), 0);
      check("rst_tile_count", 64'(tile_count), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic settle();
    repeat (3) tick();
    check("queue_empty", 64'(q.size()), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  exp_t got;
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d idx %0d, expected nothing", data, idx);
      end else begin
        got = q.pop_front();
        check("out_data", 64'(data), 64'(got.d));
        check("out_idx", 64'(idx), 64'(got.i));
        check("out_last", 64'(last), 64'(got.l));
      end
    end
    if (yumi != '0) begin
      check("yumi_onehot", 64'($onehot(yumi)), 1);
      check("yumi_only_valid", 64'(yumi & ~zv), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    z = {32'd40, 32'd30, 32'd20, 32'd10};

    // 1) full tile at full throughput
    do_reset(1'b1);
    en = 1'b1; ready = 1'b1; zv = 4'b1111;
    push_tile();
    drain(0, 4);
    zv = '0;
    @(negedge clk);
    check("t1_tile_done", 64'(tile_done), 1);
    check("t1_tile_count", 64'(tile_count), 1);
    tick();
    @(negedge clk);
    check("t1_tile_done_drop", 64'(tile_done), 0);
    settle();

    // 2) stall on lane 0 although others are valid
    do_reset(1'b0);
    en = 1'b1; ready = 1'b1; zv = 4'b1110;
    repeat (3) begin
      @(negedge clk);
      check("t2_no_yumi", 64'(yumi), 0);
      check("t2_no_valid", 64'(valid), 0);
      tick();
    end
    zv = 4'b1111;
    push_tile();
    drain(0, 4);
    zv = '0;
    settle();

    // 3) backpressure holds the first result
    do_reset(1'b0);
    en = 1'b1; ready = 1'b0; zv = 4'b1111;
    push_tile();
    drain(0, 1);
    repeat (3) begin
      @(negedge clk);
      check("t3_hold_yumi", 64'(yumi), 0);
      check("t3_hold_valid", 64'(valid), 1);
      check("t3_hold_data", 64'(data), 10);
      check("t3_hold_idx", 64'(idx), 0);
      tick();
    end
    ready = 1'b1;
    drain(1, 4);
    zv = '0;
    settle();

    // 4) enable low mid-tile at ptr=2
    do_reset(1'b0);
    en = 1'b1; ready = 1'b1; zv = 4'b1111;
    push_tile();
    drain(0, 2);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_en_off_yumi", 64'(yumi), 0);
      tick();
    end
    en = 1'b1;
    drain(2, 4);
    zv = '0;
    settle();

    // 5) async reset at ptr=3 with a buffered result
    do_reset(1'b0);
    en = 1'b1; ready = 1'b1; zv = 4'b1111;
    push_lane(0);
    push_lane(1);
    drain(0, 3);
    ready = 1'b0;
    @(negedge clk);
    check("t5_pre_valid", 64'(valid), 1);
    check("t5_pre_yumi", 64'(yumi), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(valid), 0);
    check("t5_async_yumi", 64'(yumi), 0);
    zv = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_count_after", 64'(tile_count), 0);
    check("t5_valid_after", 64'(valid), 0);
    tick();
    zv = 4'b1111; ready = 1'b1;
    push_tile();
    drain(0, 4);
    zv = '0;
    settle();

    // 6) five back-to-back tiles, 2-bit counter wraps
    do_reset(1'b0);
    en = 1'b1; ready = 1'b1; zv = 4'b1111;
    pulses = 0;
    for (int unsigned t = 0; t < 5; t++) push_tile();
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t6_yumi", 64'(yumi), 64'(1) << (c % N));
      if (tile_done) pulses++;
      tick();
    end
    zv = '0;
    @(negedge clk);
    if (tile_done) pulses++;
    tick();
    @(negedge clk);
    if (tile_done) pulses++;
    check("t6_pulses", 64'(pulses), 5);
    check("t6_tile_count", 64'(tile_count), 1);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
